// File: rtl/hyperload_tape_player.sv
// Hyperload tape player: turns FIFO bytes into EAR half-pulses, MSB first.
// Define HYPERLOAD_PILOT_EN to emit pilot tone and sync pulses at the start of each burst.
module hyperload_tape_player #(
    parameter int unsigned HALF0       = 12214,
    parameter int unsigned HALF1       = 24429,
    parameter int unsigned PILOT_HALF  = 30971,
    parameter int unsigned PILOT_COUNT = 3223,
    parameter int unsigned SYNC1       = 9529,
    parameter int unsigned SYNC2       = 10500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       ear_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PILOT   = 3'd1,
        SYNC_A  = 3'd2,
        SYNC_B  = 3'd3,
        FETCH   = 3'd4,
        LATCH   = 3'd5,
        HALF_HI = 3'd6,
        HALF_LO = 3'd7
    } state_t;

    localparam int unsigned LEN_MAX = 32'd65536;

    // Every length must fit the 16-bit down-counter; a misconfigured block never starts.
    localparam bit CFG_OK = (HALF0 >= 32'd1) && (HALF0 <= LEN_MAX) &&
                            (HALF1 >= 32'd1) && (HALF1 <= LEN_MAX) &&
                            (PILOT_HALF >= 32'd1) && (PILOT_HALF <= LEN_MAX) &&
                            (PILOT_COUNT >= 32'd1) && (PILOT_COUNT <= LEN_MAX) &&
                            (SYNC1 >= 32'd1) && (SYNC1 <= LEN_MAX) &&
                            (SYNC2 >= 32'd1) && (SYNC2 <= LEN_MAX);

    localparam logic [15:0] HALF0_M1 = 16'(HALF0 - 32'd1);
    localparam logic [15:0] HALF1_M1 = 16'(HALF1 - 32'd1);

    function automatic logic [15:0] half_len_m1(input logic bit_v);
        return bit_v ? HALF1_M1 : HALF0_M1;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        ear_q, ear_d;
    logic        busy_q;

`ifdef HYPERLOAD_PILOT_EN
    localparam logic [15:0] PILOT_HALF_M1  = 16'(PILOT_HALF - 32'd1);
    localparam logic [15:0] PILOT_COUNT_M1 = 16'(PILOT_COUNT - 32'd1);
    localparam logic [15:0] SYNC1_M1       = 16'(SYNC1 - 32'd1);
    localparam logic [15:0] SYNC2_M1       = 16'(SYNC2 - 32'd1);

    logic [15:0] pilot_cnt_q, pilot_cnt_d;

    // Pilot half-pulse counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pilot_cnt_q <= 16'd0;
        end else begin
            pilot_cnt_q <= pilot_cnt_d;
        end
    end
`endif

    // Pop is combinational so it can never fire on a cycle where the FIFO reports empty.
    assign fifo_rd = (state_q == FETCH) && !fifo_empty && enable;
    assign ear_out = ear_q;
    assign busy    = busy_q;

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            half_cnt_q <= 16'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ear_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ear_q      <= ear_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    // Next-state logic; ear_d is the EAR level for the state being entered.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ear_d      = 1'b0;
`ifdef HYPERLOAD_PILOT_EN
        pilot_cnt_d = pilot_cnt_q;
`endif
        if (!enable) begin
            state_d    = IDLE;
            half_cnt_d = 16'd0;
            bit_cnt_d  = 4'd0;
            shift_d    = 8'd0;
`ifdef HYPERLOAD_PILOT_EN
            pilot_cnt_d = 16'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && CFG_OK) begin
`ifdef HYPERLOAD_PILOT_EN
                        state_d     = PILOT;
                        half_cnt_d  = PILOT_HALF_M1;
                        pilot_cnt_d = PILOT_COUNT_M1;
                        ear_d       = 1'b1;
`else
                        state_d = FETCH;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef HYPERLOAD_PILOT_EN
                PILOT: begin
                    if (half_cnt_q == 16'd0) begin
                        if (pilot_cnt_q == 16'd0) begin
                            state_d    = SYNC_A;
                            half_cnt_d = SYNC1_M1;
                            ear_d      = 1'b1;
                        end else begin
                            pilot_cnt_d = pilot_cnt_q - 16'd1;
                            half_cnt_d  = PILOT_HALF_M1;
                            ear_d       = ~ear_q;
                        end
                    end else begin
                        half_cnt_d = half_cnt_q - 16'd1;
                        ear_d      = ear_q;
                    end
                end
                SYNC_A: begin
                    if (half_cnt_q == 16'd0) begin
                        state_d    = SYNC_B;
                        half_cnt_d = SYNC2_M1;
                    end else begin
                        half_cnt_d = half_cnt_q - 16'd1;
                        ear_d      = 1'b1;
                    end
                end
                SYNC_B: begin
                    if (half_cnt_q == 16'd0) begin
                        state_d = FETCH;
                    end else begin
                        half_cnt_d = half_cnt_q - 16'd1;
                    end
                end
`endif
                FETCH: begin
                    if (fifo_empty) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LATCH;
                    end
                end
                LATCH: begin
                    shift_d    = fifo_data;
                    bit_cnt_d  = 4'd8;
                    half_cnt_d = half_len_m1(fifo_data[7]);
                    state_d    = HALF_HI;
                    ear_d      = 1'b1;
                end
                HALF_HI: begin
                    if (half_cnt_q == 16'd0) begin
                        state_d    = HALF_LO;
                        half_cnt_d = half_len_m1(shift_q[7]);
                    end else begin
                        half_cnt_d = half_cnt_q - 16'd1;
                        ear_d      = 1'b1;
                    end
                end
                HALF_LO: begin
                    if (half_cnt_q == 16'd0) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        if (bit_cnt_q == 4'd1) begin
                            state_d = FETCH;
                        end else begin
                            state_d    = HALF_HI;
                            half_cnt_d = half_len_m1(shift_q[6]);
                            ear_d      = 1'b1;
                        end
                    end else begin
                        half_cnt_d = half_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperload_tape_player.sv
// Scoreboard bench for hyperload_tape_player: expected pulse/pop events are queued by
// the stimulus and popped by a monitor that measures ear_out runs and fifo_rd strobes.
module tb_hyperload_tape_player;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       ear_out;
    logic       busy;

    typedef struct {
        byte kind;
        int  val;
    } ev_t;

    ev_t  sb[$];
    byte  fq[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   rd_count = 0;
    bit   mon_en   = 1'b0;
    bit   rnd_block = 1'b0;

    hyperload_tape_player #(
        .HALF0(4), .HALF1(8), .PILOT_HALF(3), .PILOT_COUNT(4), .SYNC1(2), .SYNC2(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .ear_out(ear_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: data valid the cycle after the pop strobe.
    initial begin
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
    end
    always @(posedge clk) begin
        if (fifo_rd && fq.size() > 0) fifo_data <= fq.pop_front();
        fifo_empty <= (fq.size() == 0) || rnd_block;
    end

    task automatic push_ev(input byte k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_event(input byte k, input int v);
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL stream: got %c%0d, required no event", k, v);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.val != v) begin
                n_err++;
                $display("FAIL stream: got %c%0d, required %c%0d", k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: ear_out run lengths and pop strobes, plus the pop safety rules.
    bit prev_ear = 1'b0;
    bit prev_rd  = 1'b0;
    bit low_valid = 1'b0;
    int run = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (fifo_rd) begin
                rd_count++;
                check("rd_while_empty", int'(fifo_empty), 0);
                check("rd_back_to_back", int'(prev_rd), 0);
            end
            if (!mon_en) begin
                low_valid = 1'b0;
                run = 0;
            end else begin
                if (fifo_rd) check_event("R", 0);
                if (ear_out != prev_ear) begin
                    if (prev_ear) begin
                        check_event("H", run);
                        low_valid = 1'b1;
                    end else if (low_valid) begin
                        check_event("L", run);
                    end
                    run = 1;
                end else begin
                    run++;
                end
                if (!busy) low_valid = 1'b0;
            end
        end
        prev_ear = ear_out;
        prev_rd  = fifo_rd;
    end

    // Start of a burst as seen on EAR: optional pilot/sync, then the first pop.
    task automatic exp_start();
`ifdef HYPERLOAD_PILOT_EN
        push_ev("H", 3); push_ev("L", 3); push_ev("H", 3); push_ev("L", 3);
        push_ev("H", 2); push_ev("R", 0); push_ev("L", 4);
`else
        push_ev("R", 0);
`endif
    endtask

    task automatic exp_bytes(input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [7:0] b;
        int len;
        for (int k = 0; k < n; k++) begin
            b = (k == 0) ? b0 : b1;
            for (int i = 7; i >= 0; i--) begin
                len = b[i] ? 8 : 4;
                push_ev("H", len);
                if (i > 0) push_ev("L", len);
                else if (k < n - 1) begin
                    push_ev("R", 0);
                    push_ev("L", len + 2);
                end
            end
        end
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_done"}, int'(ok), 1);
        if (!ok) sb.delete();
    endtask

    initial begin
        int rd_before;
        bit ok;
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ear", int'(ear_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_rd", int'(fifo_rd), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        mon_en = 1'b1;

        // Single byte 0xA5.
        exp_start();
        exp_bytes(8'hA5, 8'h00, 1);
        fq.push_back(8'hA5);
        enable = 1'b1;
        wait_done("a5");
        check("a5_ear", int'(ear_out), 0);
        enable = 1'b0;

        // Back-to-back 0x00, 0xFF.
        exp_start();
        exp_bytes(8'h00, 8'hFF, 2);
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        enable = 1'b1;
        wait_done("00ff");
        enable = 1'b0;

        // Single byte 0x80.
        exp_start();
        exp_bytes(8'h80, 8'h00, 1);
        fq.push_back(8'h80);
        enable = 1'b1;
        wait_done("80");
        enable = 1'b0;

        // Enable dropped during bit 3 of 0x81.
        exp_start();
        push_ev("H", 8); push_ev("L", 8); push_ev("H", 4); push_ev("L", 4);
        push_ev("H", 4); push_ev("L", 4);
        fq.push_back(8'h81);
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && ear_out) begin
                ok = 1'b1;
                break;
            end
        end
        check("drop_reach_bit3", int'(ok), 1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        enable = 1'b0;
        rd_before = rd_count;
        @(negedge clk);
        check("drop_ear_before_edge", int'(ear_out), 1);
        @(negedge clk);
        check("drop_ear", int'(ear_out), 0);
        check("drop_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("drop_no_rd", rd_count, rd_before);
        check("drop_still_idle", int'(busy), 0);

        // Asynchronous reset pulse during HALF_HI.
        sb.delete();
        fq.push_back(8'hFF);
        rd_before = rd_count;
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rd_count > rd_before && ear_out) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_reach_hi", int'(ok), 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_ear", int'(ear_out), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_rd", int'(fifo_rd), 0);
        enable = 1'b0;
        #2 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_after_busy", int'(busy), 0);
        check("rst_after_ear", int'(ear_out), 0);

        // Random fifo_empty gating while bytes drain; pop rules checked by the monitor.
        fq.push_back(8'h3C);
        fq.push_back(8'hC3);
        fq.push_back(8'h5A);
        enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1 rnd_block = 1'($urandom_range(0, 1));
        end
        rnd_block = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("rand_drained", int'(ok), 1);
        enable = 1'b0;

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
